// File: rtl/sfp_acc_relu_pkg.sv
// Shared configuration, FSM encoding and lane helpers for the psum
// accumulate/ReLU stage that sits behind the pmem read port.
package sfp_acc_relu_pkg;

   localparam int COL     = 8;
   localparam int PSUM_BW = 16;
   localparam int KIJ_W   = 4;
   localparam int VEC_W   = COL * PSUM_BW;

   localparam logic signed [PSUM_BW-1:0] PSUM_MAX = {1'b0, {(PSUM_BW-1){1'b1}}};
   localparam logic signed [PSUM_BW-1:0] PSUM_MIN = {1'b1, {(PSUM_BW-1){1'b0}}};

   typedef logic signed [PSUM_BW-1:0] psum_t;

   typedef enum logic [1:0] {
      IDLE,
      ACC,
      OUT
   } state_t;

   function automatic psum_t lane_slice(input logic [VEC_W-1:0] vec, input int unsigned k);
      return psum_t'(vec[k*PSUM_BW +: PSUM_BW]);
   endfunction

endpackage

// File: rtl/sfp_acc_relu_if.sv
// Psum-in / ofmap-out handshake bundle of the accumulate/ReLU stage.
// master is the surrounding core (or bench), slave is the stage itself.
interface sfp_acc_relu_if;
   import sfp_acc_relu_pkg::*;

   logic             in_valid;
   logic             in_ready;
   logic [VEC_W-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [VEC_W-1:0] out_data;
   logic             out_sat;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_sat
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_sat
   );

endinterface

// File: rtl/sfp_sat_add_lane.sv
// One output-channel lane: saturating accumulator with first-beat load,
// plus the ReLU'd output register captured when the vector completes.
module sfp_sat_add_lane
   import sfp_acc_relu_pkg::*;
(
   input  logic  clk,
   input  logic  reset,
   input  logic  load,
   input  logic  add,
   input  logic  capture,
   input  logic  relu,
   input  psum_t din,
   output psum_t dout,
   output logic  sat
);

   psum_t                   acc_q;
   psum_t                   sum_sat;
   psum_t                   acc_next;
   logic signed [PSUM_BW:0] sum_wide;

   // One guard bit: overflow shows up as disagreeing top two bits.
   always_comb begin
      sum_wide = {acc_q[PSUM_BW-1], acc_q} + {din[PSUM_BW-1], din};
      sum_sat  = sum_wide[PSUM_BW-1:0];
      sat      = 1'b0;
      if (sum_wide[PSUM_BW] != sum_wide[PSUM_BW-1]) begin
         sat     = add;
         sum_sat = sum_wide[PSUM_BW] ? PSUM_MIN : PSUM_MAX;
      end
      acc_next = load ? din : sum_sat;
   end

   // NOTE: reset is synchronous, so it sits inside the clocked block and the
   // accumulator is a plain register, not a memory, so it is cleared too.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q <= '0;
         dout  <= '0;
      end else begin
         if (load || add)
            acc_q <= acc_next;
         if (capture)
            dout <= (relu && acc_next[PSUM_BW-1]) ? '0 : acc_next;
      end
   end

endmodule

// File: rtl/sfp_acc_relu.sv
// Accumulates len_kij psum beats per lane, applies optional ReLU and hands
// one finished ofmap vector to the output path over ready/valid.
module sfp_acc_relu
   import sfp_acc_relu_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic [KIJ_W-1:0] len_kij,
   input  logic             relu_en,
   sfp_acc_relu_if.slave    bus,
   output logic             busy
);

   state_t           state_q;
   state_t           state_d;
   logic [KIJ_W-1:0] cnt_q;
   logic [KIJ_W-1:0] cnt_inc;
   logic [KIJ_W-1:0] target_q;
   logic [KIJ_W-1:0] target_new;
   logic             relu_q;
   logic             relu_cur;
   logic             sat_q;
   logic             accept;
   logic             load;
   logic             add;
   logic             capture;
   logic [COL-1:0]   lane_sat;
   logic [VEC_W-1:0] out_vec;

   assign bus.in_ready  = !reset && (state_q != OUT);
   assign bus.out_valid = (state_q == OUT);
   assign bus.out_sat   = (state_q == OUT) && sat_q;
   assign bus.out_data  = out_vec;
   assign busy          = (state_q == ACC);

   assign accept     = bus.in_valid && bus.in_ready;
   assign target_new = (len_kij == '0) ? KIJ_W'(1) : len_kij;
   assign cnt_inc    = cnt_q + 1'b1;
   // The first beat of a vector must already see the new relu_en.
   assign relu_cur   = (state_q == IDLE) ? relu_en : relu_q;

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      add     = 1'b0;
      capture = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               load = 1'b1;
               if (target_new == KIJ_W'(1)) begin
                  capture = 1'b1;
                  state_d = OUT;
               end else begin
                  state_d = ACC;
               end
            end
         end
         ACC: begin
            if (accept) begin
               add = 1'b1;
               if (cnt_inc == target_q) begin
                  capture = 1'b1;
                  state_d = OUT;
               end
            end
         end
         OUT: begin
            if (bus.out_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: all sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         target_q <= '0;
         relu_q   <= 1'b0;
         sat_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (load) begin
            cnt_q    <= KIJ_W'(1);
            target_q <= target_new;
            relu_q   <= relu_en;
            sat_q    <= 1'b0;
         end else if (add) begin
            cnt_q <= cnt_inc;
            sat_q <= sat_q | (|lane_sat);
         end
      end
   end

   for (genvar k = 0; k < COL; k++) begin : g_lane
      psum_t lane_out;

      sfp_sat_add_lane u_lane (
         .clk     (clk),
         .reset   (reset),
         .load    (load),
         .add     (add),
         .capture (capture),
         .relu    (relu_cur),
         .din     (lane_slice(bus.in_data, k)),
         .dout    (lane_out),
         .sat     (lane_sat[k])
      );

      assign out_vec[k*PSUM_BW +: PSUM_BW] = lane_out;
   end

endmodule

// File: tb/tb_sfp_acc_relu.sv
// Directed bench for sfp_acc_relu: accumulation, ReLU, saturation,
// backpressure, gaps/config latching, len_kij=0 and mid-vector reset.
module tb_sfp_acc_relu;
   import sfp_acc_relu_pkg::*;

   logic             clk = 1'b0;
   logic             reset;
   logic [KIJ_W-1:0] len_kij;
   logic             relu_en;
   logic             busy;

   int checks  = 0;
   int errors  = 0;
   int accepts = 0;

   sfp_acc_relu_if bus ();

   sfp_acc_relu dut (
      .clk     (clk),
      .reset   (reset),
      .len_kij (len_kij),
      .relu_en (relu_en),
      .bus     (bus),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      if (reset === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1)
         accepts++;

   function automatic logic [VEC_W-1:0] rep(input logic [PSUM_BW-1:0] v);
      return {COL{v}};
   endfunction

   // Drives n beats starting at a negedge; returns whether out_valid showed
   // up before the last beat and whether in_ready was high for every beat.
   task automatic send(input logic [VEC_W-1:0] d, input int n, input bit gaps,
                       input bit perturb, output logic early, output logic ready_ok);
      early    = 1'b0;
      ready_ok = 1'b1;
      for (int i = 0; i < n; i++) begin
         if (bus.in_ready !== 1'b1) ready_ok = 1'b0;
         if (i == n - 1) early = (bus.out_valid !== 1'b0);
         bus.in_valid = 1'b1;
         bus.in_data  = d;
         @(negedge clk);
         if (perturb && i == 0) begin
            len_kij = 4'd2;
            relu_en = ~relu_en;
         end
         if (gaps && i < n - 1) begin
            bus.in_valid = 1'b0;
            bus.in_data  = '0;
            @(negedge clk);
         end
      end
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
   endtask

   // Samples the output side, then accepts it for one cycle.
   task automatic drain(output logic v, output logic [VEC_W-1:0] d, output logic s,
                        output logic r, output logic v_after);
      v = bus.out_valid;
      d = bus.out_data;
      s = bus.out_sat;
      r = bus.in_ready;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      v_after = bus.out_valid;
   endtask

   task automatic test_reset();
      reset         = 1'b1;
      len_kij       = 4'd9;
      relu_en       = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
      checks++; if (bus.out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", bus.out_data); end
      checks++; if (bus.out_sat !== 1'b0) begin errors++; $display("FAIL reset_out_sat: got %b expected 0", bus.out_sat); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      reset = 1'b0;
      #1;
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b expected 1", bus.in_ready); end
   endtask

   task automatic test_accum_pos();
      logic early, rdy, v, s, r, va;
      logic [VEC_W-1:0] d;
      len_kij = 4'd9;
      relu_en = 1'b0;
      send(rep(16'h0003), 4, 1'b0, 1'b0, early, rdy);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL accum_busy: got %b expected 1", busy); end
      send(rep(16'h0003), 5, 1'b0, 1'b0, early, rdy);
      checks++; if (early !== 1'b0) begin errors++; $display("FAIL accum_early_valid: got %b expected 0", early); end
      checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL accum_in_ready: got %b expected 1", rdy); end
      drain(v, d, s, r, va);
      checks++; if (v !== 1'b1) begin errors++; $display("FAIL accum_valid: got %b expected 1", v); end
      checks++; if (d !== rep(16'h001B)) begin errors++; $display("FAIL accum_data: got %h expected %h", d, rep(16'h001B)); end
      checks++; if (s !== 1'b0) begin errors++; $display("FAIL accum_sat: got %b expected 0", s); end
      checks++; if (r !== 1'b0) begin errors++; $display("FAIL accum_out_in_ready: got %b expected 0", r); end
      checks++; if (va !== 1'b0) begin errors++; $display("FAIL accum_valid_pulse: got %b expected 0", va); end
   endtask

   task automatic test_relu();
      logic early, rdy, v, s, r, va;
      logic [VEC_W-1:0] d;
      len_kij = 4'd9;
      relu_en = 1'b1;
      send(rep(16'hFFFB), 9, 1'b0, 1'b0, early, rdy);
      drain(v, d, s, r, va);
      checks++; if (v !== 1'b1) begin errors++; $display("FAIL relu_on_valid: got %b expected 1", v); end
      checks++; if (d !== rep(16'h0000)) begin errors++; $display("FAIL relu_on_data: got %h expected %h", d, rep(16'h0000)); end
      relu_en = 1'b0;
      send(rep(16'hFFFB), 9, 1'b0, 1'b0, early, rdy);
      drain(v, d, s, r, va);
      checks++; if (d !== rep(16'hFFD3)) begin errors++; $display("FAIL relu_off_data: got %h expected %h", d, rep(16'hFFD3)); end
      checks++; if (s !== 1'b0) begin errors++; $display("FAIL relu_off_sat: got %b expected 0", s); end
   endtask

   task automatic test_saturation();
      logic early, rdy, v, s, r, va;
      logic [VEC_W-1:0] d, din, exp;
      din = rep(16'h0001);
      din[15:0]  = 16'h7000;
      din[31:16] = 16'h8000;
      exp = rep(16'h0002);
      exp[15:0]  = 16'h7FFF;
      exp[31:16] = 16'h8000;
      len_kij = 4'd2;
      relu_en = 1'b0;
      send(din, 2, 1'b0, 1'b0, early, rdy);
      drain(v, d, s, r, va);
      checks++; if (d !== exp) begin errors++; $display("FAIL sat_data: got %h expected %h", d, exp); end
      checks++; if (s !== 1'b1) begin errors++; $display("FAIL sat_flag: got %b expected 1", s); end
      checks++; if (bus.out_sat !== 1'b0) begin errors++; $display("FAIL sat_flag_idle: got %b expected 0", bus.out_sat); end
      len_kij = 4'd1;
      send(rep(16'h0005), 1, 1'b0, 1'b0, early, rdy);
      drain(v, d, s, r, va);
      checks++; if (d !== rep(16'h0005)) begin errors++; $display("FAIL sat_next_data: got %h expected %h", d, rep(16'h0005)); end
      checks++; if (s !== 1'b0) begin errors++; $display("FAIL sat_cleared: got %b expected 0", s); end
   endtask

   task automatic test_backpressure();
      logic early, rdy, v, s, r, va;
      logic [VEC_W-1:0] d, din, exp;
      for (int k = 0; k < COL; k++) begin
         din[k*PSUM_BW +: PSUM_BW] = 16'(k * 4 + 1);
         exp[k*PSUM_BW +: PSUM_BW] = 16'(3 * (k * 4 + 1));
      end
      len_kij = 4'd3;
      relu_en = 1'b0;
      send(din, 3, 1'b0, 1'b0, early, rdy);
      for (int c = 0; c < 5; c++) begin
         checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b expected 1", c, bus.out_valid); end
         checks++; if (bus.out_data !== exp) begin errors++; $display("FAIL bp_data[%0d]: got %h expected %h", c, bus.out_data, exp); end
         checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", c, bus.in_ready); end
         bus.in_valid = 1'b1;
         bus.in_data  = rep(16'h1111);
         @(negedge clk);
      end
      drain(v, d, s, r, va);
      checks++; if (d !== exp) begin errors++; $display("FAIL bp_final_data: got %h expected %h", d, exp); end
      checks++; if (va !== 1'b0) begin errors++; $display("FAIL bp_released: got %b expected 0", va); end
      // out_ready held high while nothing is pending must be harmless.
      len_kij = 4'd2;
      bus.out_ready = 1'b1;
      send(rep(16'h0100), 2, 1'b0, 1'b0, early, rdy);
      checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL bp_restart_ready: got %b expected 1", rdy); end
      drain(v, d, s, r, va);
      checks++; if (v !== 1'b1) begin errors++; $display("FAIL bp_next_valid: got %b expected 1", v); end
      checks++; if (d !== rep(16'h0200)) begin errors++; $display("FAIL bp_next_data: got %h expected %h", d, rep(16'h0200)); end
   endtask

   task automatic test_gaps();
      logic early, rdy, v, s, r, va;
      logic [VEC_W-1:0] d, din, exp;
      for (int k = 0; k < COL; k++) begin
         din[k*PSUM_BW +: PSUM_BW] = 16'(k * 100 - 300);
         exp[k*PSUM_BW +: PSUM_BW] = 16'(9 * (k * 100 - 300));
      end
      len_kij = 4'd9;
      relu_en = 1'b0;
      send(din, 9, 1'b1, 1'b1, early, rdy);
      checks++; if (early !== 1'b0) begin errors++; $display("FAIL gaps_early_valid: got %b expected 0", early); end
      drain(v, d, s, r, va);
      checks++; if (v !== 1'b1) begin errors++; $display("FAIL gaps_valid: got %b expected 1", v); end
      checks++; if (d !== exp) begin errors++; $display("FAIL gaps_data: got %h expected %h", d, exp); end
      len_kij = 4'd9;
      relu_en = 1'b0;
      send(din, 9, 1'b0, 1'b0, early, rdy);
      drain(v, d, s, r, va);
      checks++; if (d !== exp) begin errors++; $display("FAIL b2b_data: got %h expected %h", d, exp); end
   endtask

   task automatic test_len0();
      logic early, rdy, v, s, r, va;
      logic [VEC_W-1:0] d, din;
      for (int k = 0; k < COL; k++)
         din[k*PSUM_BW +: PSUM_BW] = 16'(k * 1000 - 3000);
      len_kij = 4'd0;
      relu_en = 1'b0;
      send(din, 1, 1'b0, 1'b0, early, rdy);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL len0_busy: got %b expected 0", busy); end
      drain(v, d, s, r, va);
      checks++; if (v !== 1'b1) begin errors++; $display("FAIL len0_a_valid: got %b expected 1", v); end
      checks++; if (d !== din) begin errors++; $display("FAIL len0_a_data: got %h expected %h", d, din); end
      send(rep(16'hFFFF), 1, 1'b0, 1'b0, early, rdy);
      drain(v, d, s, r, va);
      checks++; if (v !== 1'b1) begin errors++; $display("FAIL len0_b_valid: got %b expected 1", v); end
      checks++; if (d !== rep(16'hFFFF)) begin errors++; $display("FAIL len0_b_data: got %h expected %h", d, rep(16'hFFFF)); end
   endtask

   task automatic test_reset_mid();
      logic early, rdy, v, s, r, va;
      logic [VEC_W-1:0] d;
      int base;
      len_kij = 4'd9;
      relu_en = 1'b0;
      send(rep(16'h0007), 4, 1'b0, 1'b0, early, rdy);
      reset = 1'b1;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b expected 0", busy); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b expected 0", bus.out_valid); end
      reset = 1'b0;
      base  = accepts;
      send(rep(16'h0001), 9, 1'b0, 1'b0, early, rdy);
      checks++; if (early !== 1'b0) begin errors++; $display("FAIL rmid_early_valid: got %b expected 0", early); end
      drain(v, d, s, r, va);
      checks++; if (d !== rep(16'h0009)) begin errors++; $display("FAIL rmid_data: got %h expected %h", d, rep(16'h0009)); end
      repeat (3) @(negedge clk);
      checks++; if (accepts - base !== 1) begin errors++; $display("FAIL rmid_pulses: got %0d expected 1", accepts - base); end
   endtask

   initial begin
      test_reset();
      test_accum_pos();
      test_relu();
      test_saturation();
      test_backpressure();
      test_gaps();
      test_len0();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete within time limit");
      $fatal(1, "timeout");
   end

endmodule
